// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the control-unit strobes.
//
// Holds MAR, MDR, a single-port 2^ADDR_WIDTH x 16 RAM and a 16-bit interval
// timer. After reset the RAM is cleared, then a program image is accepted on
// the valid/ready loader port while the CPU is held idle.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN enables write protection of the
// privileged-only region [0, PROTECT_TOP] for unprivileged writes.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   bus_in              internal data bus value this cycle
//   MAR_in, MDR_in      load MAR / MDR from bus_in
//   MDR_out             drive MDR onto bus_out
//   RAM_enable_read     MDR <= mem[ea]
//   RAM_enable_write    mem[ea] <= (MDR_in ? bus_in : MDR)
//   timer_in            load timer count from bus_in
//   privileged          PSW privilege bit
//   load_valid/data/last, load_ready   program image loader handshake
//   cpu_hold            keep the control unit idle (CLEAR and LOAD)
//   bus_out, bus_out_en MDR onto the bus when MDR_out in RUN
//   timeout             timer expired
//   mem_fault           one-cycle pulse after an illegal access
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned PROTECT_TOP = 32'h1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_in,
  input  logic        MAR_in,
  input  logic        MDR_in,
  input  logic        MDR_out,
  input  logic        RAM_enable_read,
  input  logic        RAM_enable_write,
  input  logic        timer_in,
  input  logic        privileged,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic [15:0] bus_out,
  output logic        bus_out_en,
  output logic        timeout,
  output logic        mem_fault
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [15:0]           mdr_q, mdr_d;
  logic [15:0]           count_q, count_d;
  logic                  armed_q, armed_d;
  logic                  fault_q, fault_d;

  logic [15:0]           mem [Depth];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;

  logic [ADDR_WIDTH-1:0] ea;
  logic [15:0]           rd_data;
  logic                  run;

`ifdef MEM_WRITE_PROTECT_EN
  logic                  wr_protected;
  assign wr_protected = !privileged && (32'(ea) <= PROTECT_TOP);
`else
  logic                  unused_cfg;
  assign unused_cfg = privileged ^ (PROTECT_TOP == 32'd0);
`endif

  // MAR bypass lets a fetch load MAR and read in the same cycle.
  assign ea      = MAR_in ? bus_in[ADDR_WIDTH-1:0] : mar_q;
  assign rd_data = mem[ea];
  assign run     = (state_q == StRun);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    count_d    = count_q;
    armed_d    = armed_q;
    fault_d    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = ea;
    mem_wdata  = '0;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;  // wraps to 0 on entry to LOAD
        if (ptr_q == LastAddr) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = load_data;
          ptr_d     = ptr_q + 1'b1;
          if (load_last || (ptr_q == LastAddr)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cpu_hold = 1'b0;
        if (MAR_in) begin
          mar_d = bus_in[ADDR_WIDTH-1:0];
        end
        if (RAM_enable_read && RAM_enable_write) begin
          // Conflicting strobes: no RAM access, MDR held.
          fault_d = 1'b1;
        end else if (RAM_enable_read) begin
          mdr_d = rd_data;
        end else begin
          if (MDR_in) begin
            mdr_d = bus_in;
          end
          if (RAM_enable_write) begin
`ifdef MEM_WRITE_PROTECT_EN
            if (wr_protected) begin
              fault_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = MDR_in ? bus_in : mdr_q;
            end
`else
            mem_we    = 1'b1;
            mem_wdata = MDR_in ? bus_in : mdr_q;
`endif
          end
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase

    // Timer runs in every state; only loading is gated to RUN.
    if (timer_in && run) begin
      count_d = bus_in;
      armed_d = |bus_in;
    end else if (armed_q && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      count_q <= count_d;
      armed_q <= armed_d;
      fault_q <= fault_d;
    end
  end

  // RAM has no reset; CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign bus_out_en = MDR_out && run;
  assign bus_out    = bus_out_en ? mdr_q : '0;
  assign timeout    = armed_q && (count_q == '0);
  assign mem_fault  = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] bus_in;
  logic        MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write, timer_in;
  logic        privileged;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready, cpu_hold, bus_out_en, timeout, mem_fault;
  logic [15:0] bus_out;

  int checks;
  int failures;

  mem_responder #(
    .ADDR_WIDTH (8),
    .PROTECT_TOP(32'h1F)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus_in          (bus_in),
    .MAR_in          (MAR_in),
    .MDR_in          (MDR_in),
    .MDR_out         (MDR_out),
    .RAM_enable_read (RAM_enable_read),
    .RAM_enable_write(RAM_enable_write),
    .timer_in        (timer_in),
    .privileged      (privileged),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_last       (load_last),
    .load_ready      (load_ready),
    .cpu_hold        (cpu_hold),
    .bus_out         (bus_out),
    .bus_out_en      (bus_out_en),
    .timeout         (timeout),
    .mem_fault       (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mi, mdi, mo, rd, wr, pr;
    logic [15:0] bus;
    logic [15:0] ebus;
    logic        een, ef;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic mi, input logic mdi, input logic mo, input logic rd,
                              input logic wr, input logic pr, input logic [15:0] bus,
                              input logic [15:0] ebus, input logic een, input logic ef);
    vec_t v;
    v.mi = mi; v.mdi = mdi; v.mo = mo; v.rd = rd; v.wr = wr; v.pr = pr;
    v.bus = bus; v.ebus = ebus; v.een = een; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One rising edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobes(input logic mi, input logic mdi, input logic mo, input logic rd,
                         input logic wr, input logic pr, input logic [15:0] bus);
    MAR_in = mi; MDR_in = mdi; MDR_out = mo; RAM_enable_read = rd;
    RAM_enable_write = wr; privileged = pr; bus_in = bus;
  endtask

  logic [15:0] beats[3];
  logic [15:0] exp_word;
  int          cnt;
  bit          hold_ok;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    timer_in = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_timeout", timeout, 0);
    check("rst_mem_fault", mem_fault, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_bus_out", bus_out, 0);
    check("rst_bus_out_en", bus_out_en, 0);

    // CLEAR: junk strobes must be ignored.
    strobes(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    reset_n = 1'b1;
    cnt = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cnt++;
      #1;
      if (!cpu_hold || bus_out_en) hold_ok = 1'b0;
      if (load_ready) break;
    end
    check("clear_cycles", cnt, 256);
    check("clear_hold", hold_ok, 1);

    // LOAD: three beats, last on the third.
    beats[0] = 16'h1234;
    beats[1] = 16'hABCD;
    beats[2] = 16'h0000;
    for (int b = 0; b < 3; b++) begin
      load_valid = 1'b1;
      load_data = beats[b];
      load_last = (b == 2);
      tick();
      #1;
      check($sformatf("beat%0d_cpu_hold", b), cpu_hold, (b < 2) ? 1 : 0);
      check($sformatf("beat%0d_load_ready", b), load_ready, (b < 2) ? 1 : 0);
    end
    // Extra beat offered in RUN must never be accepted.
    load_data = 16'h9999;
    load_last = 1'b0;

    // MDR still at reset value despite strobes during CLEAR/LOAD.
    strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("mdr_after_load", bus_out, 16'h0000);
    check("en_after_load", bus_out_en, 1);
    tick();

    // Scan all of RAM through the MAR bypass read path.
    for (int a = 0; a < 256; a++) begin
      strobes(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'(a));
      tick();
      strobes(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      exp_word = (a == 0) ? 16'h1234 : (a == 1) ? 16'hABCD : 16'h0000;
      #1;
      check($sformatf("ram[%0d]", a), bus_out, exp_word);
      tick();
    end

    //              mi    mdi   mo    rd    wr    pr    bus       ebus      en    fault
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hABCD, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h5A5A, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'hBEEF, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 1'b1, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCAFE, 16'h0000, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hCAFE, 1'b1, Prot);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000,
                  Prot ? 16'h0000 : 16'hCAFE, 1'b1, 1'b0);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hD00D, 16'h0000, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hD00D, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hD00D, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      strobes(vecs[i].mi, vecs[i].mdi, vecs[i].mo, vecs[i].rd, vecs[i].wr, vecs[i].pr,
              vecs[i].bus);
      #1;
      check($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].ebus);
      check($sformatf("vec%0d_bus_out_en", i), bus_out_en, vecs[i].een);
      check($sformatf("vec%0d_mem_fault", i), mem_fault, vecs[i].ef);
      tick();
    end

    // Timer: load 5, expire exactly 5 edges later and hold.
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    timer_in = 1'b1;
    tick();
    timer_in = 1'b0;
    bus_in = 16'h0000;
    #1;
    check("timer_k0", timeout, 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      #1;
      check($sformatf("timer_k%0d", k), timeout, (k >= 5) ? 1 : 0);
    end
    // Load 0: disarm, timeout low and stays low.
    timer_in = 1'b1;
    bus_in = 16'h0000;
    tick();
    timer_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("timer_zero%0d", k), timeout, 0);
      tick();
    end

    // Mid-operation reset aborts immediately.
    timer_in = 1'b1;
    bus_in = 16'd3;
    tick();
    timer_in = 1'b0;
    bus_in = 16'h0000;
    repeat (3) tick();
    MDR_out = 1'b1;
    #1;
    check("pre_rst_timeout", timeout, 1);
    check("pre_rst_bus_out", bus_out, 16'hD00D);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_timeout", timeout, 0);
    check("midrst_bus_out_en", bus_out_en, 0);
    check("midrst_bus_out", bus_out, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_load_ready", load_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // timer_in is ignored outside RUN.
    timer_in = 1'b1;
    bus_in = 16'd2;
    repeat (6) tick();
    #1;
    check("clear_timer_ignored", timeout, 0);
    check("clear_again_hold", cpu_hold, 1);
    check("clear_again_ready", load_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
